// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared types and constants for the ADC scan controller.
//   - scan_state_e : controller FSM state encoding
//   - CNT_1US_DEF  : default clk cycles per 1 us tick
//   - *_W          : channel / data / delay / average-exponent / mask widths
package adc_scan_pkg;

  localparam int CNT_1US_DEF = 50;

  localparam int CH_W    = 4;
  localparam int DATA_W  = 12;
  localparam int DLY_W   = 16;
  localparam int NUM_B_W = 5;
  localparam int MASK_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    CONV = 2'd2,
    GAP  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// adc_scan_ctrl_if: controller <-> converter handshake bundle.
//   ad_start  : one-cycle start pulse from the controller
//   ad_chan   : channel to convert
//   ad_dly    : settle delay in us
//   ad_num_b  : log2 of averaging count
//   ad_data   : conversion result, meaningful only while ad_done is high
//   ad_done   : one-cycle completion pulse from the converter
// Handshake: the controller raises ad_start for exactly one cycle and holds
// ad_chan/ad_dly/ad_num_b stable from that cycle until it samples ad_done high.
// The converter answers with one ad_done pulse carrying ad_data; ad_done seen
// while no conversion is outstanding is ignored by the controller.
// Modports: master = controller side, slave = converter side.
interface adc_scan_ctrl_if;
  import adc_scan_pkg::*;

  logic               ad_start;
  logic [CH_W-1:0]    ad_chan;
  logic [DLY_W-1:0]   ad_dly;
  logic [NUM_B_W-1:0] ad_num_b;
  logic [DATA_W-1:0]  ad_data;
  logic               ad_done;

  modport master (
    output ad_start, ad_chan, ad_dly, ad_num_b,
    input  ad_data, ad_done
  );

  modport slave (
    input  ad_start, ad_chan, ad_dly, ad_num_b,
    output ad_data, ad_done
  );

endinterface

// File: rtl/adc_us_tick.sv
// adc_us_tick: 1 us tick generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count while high
//   clr        : synchronous clear of the prescaler (has priority over en)
//   tick       : one-cycle pulse every CNT enabled cycles
module adc_us_tick #(
  parameter int CNT = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CNT > 1) ? $clog2(CNT) : 1;
  localparam logic [W-1:0] LAST = W'(CNT - 1);

  logic [W-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: sequences an external ADC over the enabled channels of a
// mask, one conversion at a time, optionally repeating scans after a gap.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   scan_start          : one-cycle pulse, starts a scan (only honoured in IDLE)
//   scan_cont           : level, repeat scans while high
//   ch_mask             : bit i enables channel i
//   dly_cfg, num_b_cfg  : forwarded to the converter per conversion
//   ivl_cfg             : gap between repeated scans in us
//   ad                  : converter handshake (adc_scan_ctrl_if.master)
//   res_valid/chan/data/err : one-cycle result strobe with channel, data, error
//   scan_done           : one-cycle end-of-scan pulse
//   busy                : high whenever the FSM is not IDLE
// Optional feature: define ADC_SCAN_TIMEOUT_EN to enable the conversion
// watchdog (TO_US us without ad_done yields an error result). Without it the
// controller waits indefinitely in CONV and res_err is tied low.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int CH_NUM  = 8,
  parameter int CNT_1US = CNT_1US_DEF,
  parameter int TO_US   = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_start,
  input  logic               scan_cont,
  input  logic [MASK_W-1:0]  ch_mask,
  input  logic [DLY_W-1:0]   dly_cfg,
  input  logic [NUM_B_W-1:0] num_b_cfg,
  input  logic [DLY_W-1:0]   ivl_cfg,
  adc_scan_ctrl_if.master    ad,
  output logic               res_valid,
  output logic [CH_W-1:0]    res_chan,
  output logic [DATA_W-1:0]  res_data,
  output logic               res_err,
  output logic               scan_done,
  output logic               busy
);

  // The us counter serves both the inter-scan gap (16-bit ivl) and the
  // watchdog, so it must be wide enough for whichever is larger.
  localparam int US_W = (TO_US > 65535) ? $clog2(TO_US + 1) : 16;
  localparam logic [4:0] CH_END = 5'(CH_NUM);

  scan_state_e        state;
  logic [4:0]         ch_idx;   // must reach CH_NUM (up to 16)
  logic [MASK_W-1:0]  sh_mask;
  logic [DLY_W-1:0]   sh_dly;
  logic [NUM_B_W-1:0] sh_num_b;
  logic [DLY_W-1:0]   sh_ivl;
  logic [US_W-1:0]    us_cnt;
  logic               tick;
  logic               tick_en;

  // Every entry into CONV or GAP comes from SEL, where the prescaler is held
  // clear, so each of those states starts with a fresh 1 us period.
  assign tick_en = (state == CONV) || (state == GAP);
  assign busy    = (state != IDLE);

  adc_us_tick #(.CNT(CNT_1US)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en),
    .clr  (!tick_en),
    .tick (tick)
  );

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam logic [US_W-1:0] TO_LAST = US_W'(TO_US - 1);
  logic res_err_q;
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch_idx      <= '0;
      sh_mask     <= '0;
      sh_dly      <= '0;
      sh_num_b    <= '0;
      sh_ivl      <= '0;
      us_cnt      <= '0;
      ad.ad_start <= 1'b0;
      ad.ad_chan  <= '0;
      ad.ad_dly   <= '0;
      ad.ad_num_b <= '0;
      res_valid   <= 1'b0;
      res_chan    <= '0;
      res_data    <= '0;
      scan_done   <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
      res_err_q   <= 1'b0;
`endif
    end else begin
      ad.ad_start <= 1'b0;
      res_valid   <= 1'b0;
      scan_done   <= 1'b0;

      case (state)
        IDLE: begin
          if (scan_start) begin
            sh_mask  <= ch_mask;
            sh_dly   <= dly_cfg;
            sh_num_b <= num_b_cfg;
            sh_ivl   <= ivl_cfg;
            ch_idx   <= '0;
            state    <= SEL;
          end
        end

        SEL: begin
          us_cnt <= '0;
          if (ch_idx == CH_END) begin
            scan_done <= 1'b1;
            state     <= scan_cont ? GAP : IDLE;
          end else if (sh_mask[ch_idx[3:0]]) begin
            ad.ad_start <= 1'b1;
            ad.ad_chan  <= ch_idx[3:0];
            ad.ad_dly   <= sh_dly;
            ad.ad_num_b <= sh_num_b;
            state       <= CONV;
          end else begin
            ch_idx <= ch_idx + 1'b1;
          end
        end

        CONV: begin
          if (ad.ad_done) begin
            res_data  <= ad.ad_data;
            res_chan  <= ch_idx[3:0];
            res_valid <= 1'b1;
`ifdef ADC_SCAN_TIMEOUT_EN
            res_err_q <= 1'b0;
`endif
            ch_idx    <= ch_idx + 1'b1;
            state     <= SEL;
          end
`ifdef ADC_SCAN_TIMEOUT_EN
          else if (tick && (us_cnt == TO_LAST)) begin
            res_data  <= '0;
            res_chan  <= ch_idx[3:0];
            res_valid <= 1'b1;
            res_err_q <= 1'b1;
            ch_idx    <= ch_idx + 1'b1;
            state     <= SEL;
          end
`endif
          else if (tick) begin
            us_cnt <= us_cnt + 1'b1;
          end
        end

        GAP: begin
          // Dropping scan_cont wins over a restart in the same cycle.
          if (!scan_cont) begin
            state <= IDLE;
          end else if (us_cnt == US_W'(sh_ivl)) begin
            sh_mask  <= ch_mask;
            sh_dly   <= dly_cfg;
            sh_num_b <= num_b_cfg;
            sh_ivl   <= ivl_cfg;
            ch_idx   <= '0;
            state    <= SEL;
          end else if (tick) begin
            us_cnt <= us_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: self-checking bench for adc_scan_ctrl (CH_NUM=4,
// CNT_1US=10, TO_US=5). A behavioural converter answers 0x100+chan ten
// cycles after each ad_start unless the channel is listed in no_answer.
// Expected conversions and results are derived per scan from the mask.
module tb_adc_scan_ctrl;
  import adc_scan_pkg::*;

  localparam int CH_NUM  = 4;
  localparam int CNT_1US = 10;
  localparam int TO_US   = 5;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst_n;
  logic        scan_start;
  logic        scan_cont;
  logic [15:0] ch_mask;
  logic [15:0] dly_cfg;
  logic [4:0]  num_b_cfg;
  logic [15:0] ivl_cfg;
  logic        res_valid;
  logic [3:0]  res_chan;
  logic [11:0] res_data;
  logic        res_err;
  logic        scan_done;
  logic        busy;

  adc_scan_ctrl_if bus ();

  adc_scan_ctrl #(.CH_NUM(CH_NUM), .CNT_1US(CNT_1US), .TO_US(TO_US)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_start(scan_start),
    .scan_cont (scan_cont),
    .ch_mask   (ch_mask),
    .dly_cfg   (dly_cfg),
    .num_b_cfg (num_b_cfg),
    .ivl_cfg   (ivl_cfg),
    .ad        (bus),
    .res_valid (res_valid),
    .res_chan  (res_chan),
    .res_data  (res_data),
    .res_err   (res_err),
    .scan_done (scan_done),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] exp_q[$];        // {err, chan, data}
  logic [3:0]  exp_start_q[$];  // channels expected on ad_start
  logic [15:0] cur_dly;
  logic [4:0]  cur_numb;
  logic [15:0] no_answer = 16'h0;

  int done_cnt = 0, start_cnt = 0, res_cnt = 0;
  int last_done_cyc = 0, last_start_cyc = 0;
  logic prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a scan visits enabled channels 0..CH_NUM-1 in order.
  task automatic push_expected(input logic [15:0] mask);
    for (int i = 0; i < CH_NUM; i++) begin
      if (mask[i]) begin
        exp_start_q.push_back(4'(i));
        if (no_answer[i]) exp_q.push_back({1'b1, 4'(i), 12'h000});
        else              exp_q.push_back({1'b0, 4'(i), 12'h100 + 12'(i)});
      end
    end
  endtask

  // ---------------- converter model ----------------
  int         conv_left = 0;
  logic [3:0] conv_ch = '0;

  initial begin
    bus.ad_done = 1'b0;
    bus.ad_data = '0;
    forever begin
      @(negedge clk);
      if (bus.ad_done) begin
        bus.ad_done = 1'b0;
        bus.ad_data = 12'($urandom);
      end
      if (bus.ad_start) begin
        conv_ch   = bus.ad_chan;
        conv_left = no_answer[bus.ad_chan] ? 0 : 10;
      end else if (conv_left > 0) begin
        conv_left--;
        if (conv_left == 0) begin
          bus.ad_done = 1'b1;
          bus.ad_data = 12'h100 + {8'h00, conv_ch};
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.ad_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      check("ad_start_pulse", prev_start, 0);
      check("ad_start_expected", exp_start_q.size() != 0, 1);
      if (exp_start_q.size() != 0) check("ad_chan", bus.ad_chan, exp_start_q.pop_front());
      check("ad_dly", bus.ad_dly, cur_dly);
      check("ad_num_b", bus.ad_num_b, cur_numb);
    end
    prev_start = bus.ad_start;
    if (res_valid) begin
      res_cnt++;
      check("res_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("res", {res_err, res_chan, res_data}, exp_q.pop_front());
    end
    if (scan_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    check("scan_done_seen", done_cnt != d0, 1);
  endtask

  task automatic wait_start(input int s0, input int budget);
    int k = 0;
    while (start_cnt == s0 && k < budget) begin
      step();
      k++;
    end
    check("ad_start_seen", start_cnt != s0, 1);
  endtask

  task automatic pulse_start();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] mask, input logic [15:0] dly, input logic [4:0] nb);
    ch_mask   = mask;
    dly_cfg   = dly;
    num_b_cfg = nb;
    cur_dly   = dly;
    cur_numb  = nb;
  endtask

  task automatic run_scan(input logic [15:0] mask, input logic [15:0] dly, input logic [4:0] nb);
    int d0;
    set_cfg(mask, dly, nb);
    push_expected(mask);
    d0 = done_cnt;
    pulse_start();
    wait_done(d0, 2000);
    repeat (3) step();
    check("res_left", exp_q.size(), 0);
    check("start_left", exp_start_q.size(), 0);
    check("busy_after_scan", busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ad_start"},  bus.ad_start, 0);
    check({tag, "_ad_chan"},   bus.ad_chan, 0);
    check({tag, "_ad_dly"},    bus.ad_dly, 0);
    check({tag, "_ad_num_b"},  bus.ad_num_b, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_chan"},  res_chan, 0);
    check({tag, "_res_data"},  res_data, 0);
    check({tag, "_res_err"},   res_err, 0);
    check({tag, "_scan_done"}, scan_done, 0);
    check({tag, "_busy"},      busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, s0, c0, dcyc, diff;
    rst_n = 1'b0;
    scan_start = 1'b0;
    scan_cont = 1'b0;
    ch_mask = '0;
    dly_cfg = '0;
    num_b_cfg = '0;
    ivl_cfg = '0;
    cur_dly = '0;
    cur_numb = '0;
    repeat (3) step();
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (2) step();

    // Full mask, then a sparse mask.
    run_scan(16'h000F, 16'h1234, 5'd3);
    run_scan(16'h0005, 16'h00A0, 5'd7);

    // Empty mask: scan_done CH_NUM+1 cycles after the start edge, no ad_start.
    set_cfg(16'h0000, 16'h0001, 5'd1);
    d0 = done_cnt;
    s0 = start_cnt;
    c0 = cyc + 1;
    pulse_start();
    wait_done(d0, 100);
    check("zero_mask_latency", last_done_cyc - c0, CH_NUM + 1);
    check("zero_mask_no_start", start_cnt, s0);
    repeat (3) step();

    // Randomized masks (bits above CH_NUM must be ignored).
    for (int t = 0; t < 6; t++) begin
      run_scan(16'($urandom_range(0, 65535)), 16'($urandom), 5'($urandom_range(0, 31)));
    end

    // scan_start and ch_mask change during CONV are ignored.
    set_cfg(16'h0005, 16'h0042, 5'd2);
    push_expected(16'h0005);
    d0 = done_cnt;
    s0 = start_cnt;
    pulse_start();
    wait_start(s0, 50);
    ch_mask = 16'h000F;
    pulse_start();
    wait_done(d0, 2000);
    repeat (40) step();
    check("midscan_one_done", done_cnt, d0 + 1);
    check("midscan_res_left", exp_q.size(), 0);
    check("midscan_start_left", exp_start_q.size(), 0);

    // Continuous scan with a 3 us gap, then drop scan_cont inside GAP.
    set_cfg(16'h0001, 16'h0007, 5'd4);
    ivl_cfg = 16'd3;
    scan_cont = 1'b1;
    push_expected(16'h0001);
    push_expected(16'h0001);
    d0 = done_cnt;
    pulse_start();
    wait_done(d0, 2000);
    dcyc = last_done_cyc;
    s0 = start_cnt;
    wait_start(s0, 200);
    diff = last_start_cyc - dcyc;
    check("gap_latency_in_range", (diff >= 3 * CNT_1US - 2) && (diff <= 3 * CNT_1US + 2), 1);
    d0 = done_cnt;
    wait_done(d0, 2000);
    scan_cont = 1'b0;
    step();
    check("gap_drop_busy", busy, 0);
    repeat (60) step();
    check("gap_drop_no_restart", done_cnt, d0 + 1);
    check("gap_res_left", exp_q.size(), 0);
    ivl_cfg = 16'd0;

`ifdef ADC_SCAN_TIMEOUT_EN
    // Channel 1 never answers: watchdog error result, channel 2 still converts.
    no_answer = 16'h0002;
    run_scan(16'h0007, 16'h0011, 5'd1);
    no_answer = 16'h0000;
`endif

    // Reset during CONV: ad_done after release must be ignored.
    set_cfg(16'h0001, 16'h0099, 5'd6);
    exp_start_q.push_back(4'd0);
    d0 = done_cnt;
    s0 = start_cnt;
    pulse_start();
    wait_start(s0, 50);
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    c0 = res_cnt;
    repeat (25) step();
    check("rst_conv_no_res", res_cnt, c0);
    check("rst_conv_no_done", done_cnt, d0);
    check_reset_values("rst_conv");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter CH_NUM, default 8, number of channels scanned (1..16), indices 0..CH_NUM-1.
REQ-002 SHALL have parameter CNT_1US, default 50, clk cycles per 1 us tick.
REQ-003 SHALL have parameter TO_US, default 65535, conversion timeout in us (used only per REQ-024).
REQ-004 SHALL have ports:
 clk  in  1  single clock for all logic
 rst_n  in  1  asynchronous active-low reset
 scan_start  in  1  one-cycle pulse, starts a scan
 scan_cont  in  1  level, repeat scans while high
 ch_mask  in  16  bit i=1 enables channel i
 dly_cfg  in  16  settle delay in us, passed to converter
 num_b_cfg  in  5  log2 of average count, passed to converter
 ivl_cfg  in  16  gap between repeated scans in us
 ad_start  out  1  converter start pulse
 ad_chan  out  4  converter channel
 ad_dly  out  16  converter delay
 ad_num_b  out  5  converter average exponent
 ad_data  in  12  converter result, valid while ad_done high
 ad_done  in  1  converter completion pulse
 res_valid  out  1  one-cycle result strobe
 res_chan  out  4  channel of res_data
 res_data  out  12  captured result
 res_err  out  1  result invalid (timeout)
 scan_done  out  1  one-cycle end-of-scan pulse
 busy  out  1  high whenever state is not IDLE

Function
REQ-005 SHALL implement FSM states IDLE, SEL, CONV, GAP.
REQ-006 IDLE: scan_start SHALL latch ch_mask, dly_cfg, num_b_cfg, ivl_cfg into shadow registers, clear ch_idx to 0, enter SEL next cycle.
REQ-007 scan_start outside IDLE SHALL be ignored; shadow values SHALL not change mid-scan.
REQ-008 SEL: if ch_idx == CH_NUM, SHALL pulse scan_done for one cycle and go to GAP if scan_cont is high, else IDLE.
REQ-009 SEL: if shadow mask bit ch_idx is 0, SHALL increment ch_idx and remain in SEL (one channel per cycle).
REQ-010 SEL: if mask bit is 1, SHALL pulse ad_start for exactly one cycle with ad_chan=ch_idx and enter CONV.
REQ-011 ad_chan, ad_dly, ad_num_b SHALL hold stable from the ad_start cycle until ad_done is received.
REQ-012 CONV: on ad_done, SHALL register res_data=ad_data, res_chan=ch_idx, res_err=0, and assert res_valid the following cycle for one cycle.
REQ-013 After the ad_done cycle, SHALL increment ch_idx and return to SEL.
REQ-014 ad_done outside CONV SHALL be ignored.
REQ-015 All-zero shadow mask SHALL produce scan_done CH_NUM+1 cycles after scan_start with no ad_start.
REQ-016 GAP: SHALL count ivl_cfg 1 us ticks; at terminal count SHALL relatch shadows from inputs, clear ch_idx, enter SEL.
REQ-017 ivl_cfg==0 SHALL mean restart on the first GAP cycle.
REQ-018 scan_cont low in any GAP cycle SHALL force IDLE next cycle; scan_cont low during SEL/CONV SHALL let the current scan finish.
REQ-019 us tick counter SHALL run only in GAP or CONV and clear on state entry.

Reset
REQ-020 rst_n low SHALL force state IDLE, ch_idx 0, all counters and shadows 0.
REQ-021 Reset values: ad_start 0, ad_chan 0, ad_dly 0, ad_num_b 0, res_valid 0, res_chan 0, res_data 0, res_err 0, scan_done 0, busy 0.
REQ-022 Reset mid-conversion SHALL abort without any res_valid or scan_done; a later ad_done SHALL be ignored.

Configuration
REQ-023 Macro ADC_SCAN_TIMEOUT_EN SHALL select conversion watchdog.
REQ-024 With ADC_SCAN_TIMEOUT_EN: if CONV lasts TO_US ticks without ad_done, SHALL emit res_valid with res_err=1, res_data=0, advance ch_idx, return to SEL.
REQ-025 Without it: CONV SHALL wait indefinitely; res_err SHALL be constant 0; port list unchanged.

Structure
REQ-026 Package adc_scan_pkg SHALL hold state encoding, CNT_1US default, channel/data/delay widths.
REQ-027 Sub-module adc_us_tick SHALL generate the 1 us tick (enable, clear, tick out).

Verification
REQ-028 CH_NUM=4, mask=0x000F, converter model returns 0x100+chan after 10 cycles -> 4 res_valid, chans 0..3, data 0x100..0x103, then one scan_done.
REQ-029 mask=0x0005 -> ad_start only for chans 0 and 2; mask=0 -> scan_done 5 cycles after scan_start, no ad_start.
REQ-030 scan_cont=1, ivl_cfg=3 -> second scan's first ad_start 3*CNT_1US(+-2) cycles after scan_done; drop scan_cont in GAP -> IDLE, busy low next cycle.
REQ-031 scan_start pulsed during CONV, ch_mask changed mid-scan -> ignored, scan uses original mask.
REQ-032 With ADC_SCAN_TIMEOUT_EN, TO_US=5, model never answers chan 1 -> chan 1 res_err=1 after 5 us, chan 2 converted normally.
REQ-033 rst_n low during CONV, ad_done arrives after release -> no res_valid, all outputs at reset values.
